// File: rtl/any1_pkg.sv
// Shared types for the any1 register-fetch stage: decode/execute records and the
// writeback forwarding entry.
package any1_pkg;

  localparam int NREGS = 64;
  localparam int WID   = 64;
  localparam int RIDX  = $clog2(NREGS);

  typedef struct packed {
    logic [1:0]  Stream;
    logic        Stream_inc;
    logic [5:0]  rid;
    logic [31:0] ir;
    logic [31:0] ip;
    logic [31:0] pip;
    logic        predict_taken;
    logic        ui;
    logic        rfwr;
    logic [7:0]  Ra;
    logic [7:0]  Rb;
    logic [7:0]  Rc;
    logic [7:0]  Rd;
    logic [7:0]  Rt;
    logic [63:0] imm;
  } sDecode;

  typedef struct packed {
    logic [1:0]  Stream;
    logic        Stream_inc;
    logic [5:0]  rid;
    logic [31:0] ir;
    logic [31:0] ip;
    logic [31:0] pip;
    logic        predict_taken;
    logic        ui;
    logic        rfwr;
    logic [7:0]  Rt;
    logic [63:0] imm;
    logic [63:0] ia;
    logic [63:0] ib;
    logic [63:0] ic;
    logic [63:0] id;
    logic        iav;
    logic        ibv;
    logic        icv;
    logic        idv;
    logic        itv;
  } sExecute;

  typedef struct packed {
    logic            v;
    logic [RIDX-1:0] Rt;
    logic [WID-1:0]  res;
  } sBypassBuf;

endpackage

// File: rtl/any1_scoreboard.sv
// Per-register pending bits for in-flight results; register 0 is never pending.
// A set and a clear of the same register in one cycle leaves it pending.
module any1_scoreboard
  import any1_pkg::*;
#(
  parameter int NREGS = any1_pkg::NREGS,
  localparam int IW   = $clog2(NREGS)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               set_v,
  input  logic [IW-1:0]      set_idx,
  input  logic               clr_v,
  input  logic [IW-1:0]      clr_idx,
  input  logic [3:0][IW-1:0] lk_idx,
  output logic [3:0]         lk_pend
);

  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] pend_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pend_next[gi] = 1'b0;
      end else begin : g_reg
        assign pend_next[gi] = flush                                ? 1'b0 :
                               (set_v && set_idx == IW'(gi))        ? 1'b1 :
                               (clr_v && clr_idx == IW'(gi))        ? 1'b0 :
                                                                      pend_reg[gi];
      end
    end

    for (gi = 0; gi < 4; gi++) begin : g_lookup
      assign lk_pend[gi] = pend_reg[lk_idx[gi]];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

endmodule

// File: rtl/any1_regfetch.sv
// Register-fetch stage: 4-read/1-write register file, RAW scoreboard, registered execute record.
// Define ANY1_RF_BYPASS_EN to forward a same-cycle writeback into the operands.
module any1_regfetch
  import any1_pkg::*;
#(
  parameter int NREGS = any1_pkg::NREGS,
  parameter int WID   = any1_pkg::WID
)(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           dec_v_i,
  output logic           dec_rdy_o,
  input  sDecode         dec_i,
  input  logic           wb_v_i,
  input  logic [5:0]     wb_Rt_i,
  input  logic [WID-1:0] wb_res_i,
  output logic           ex_v_o,
  input  logic           ex_rdy_i,
  output sExecute        ex_o
);

  localparam int IW = $clog2(NREGS);

  logic [WID-1:0]      regfile [NREGS];
  logic [3:0][IW-1:0]  src_idx;
  logic [3:0]          src_pend;
  logic [3:0]          src_hz;
  logic [3:0][WID-1:0] opnd;
  logic                hz;
  logic                accept;
  logic                ex_v_reg;
  logic                ex_v_next;
  sExecute             ex_reg;
  sExecute             ex_next;
  logic                unused_bits;

  // Only the low index bits select a register; the top bits are don't-care.
  assign src_idx[0] = dec_i.Ra[IW-1:0];
  assign src_idx[1] = dec_i.Rb[IW-1:0];
  assign src_idx[2] = dec_i.Rc[IW-1:0];
  assign src_idx[3] = dec_i.Rd[IW-1:0];
  assign unused_bits = ^{dec_i.Ra[7:IW], dec_i.Rb[7:IW], dec_i.Rc[7:IW], dec_i.Rd[7:IW]};

  always_ff @(posedge clk_i) begin
    if (wb_v_i && wb_Rt_i[IW-1:0] != '0)
      regfile[wb_Rt_i[IW-1:0]] <= wb_res_i;
  end

  any1_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk     (clk_i),
    .rst     (rst_i),
    .flush   (flush_i),
    .set_v   (accept & dec_i.rfwr),
    .set_idx (dec_i.Rt[IW-1:0]),
    .clr_v   (wb_v_i),
    .clr_idx (wb_Rt_i[IW-1:0]),
    .lk_idx  (src_idx),
    .lk_pend (src_pend)
  );

`ifdef ANY1_RF_BYPASS_EN
  sBypassBuf byp;
  assign byp = '{v: wb_v_i, Rt: wb_Rt_i[IW-1:0], res: wb_res_i};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
`ifdef ANY1_RF_BYPASS_EN
      logic hit;
      assign hit        = byp.v && byp.Rt == src_idx[gi];
      assign src_hz[gi] = src_pend[gi] & ~hit;
      assign opnd[gi]   = (src_idx[gi] == '0) ? '0 :
                          hit                 ? byp.res :
                                                regfile[src_idx[gi]];
`else
      // Without forwarding the stall lasts until the writeback has landed in the array.
      assign src_hz[gi] = src_pend[gi];
      assign opnd[gi]   = (src_idx[gi] == '0) ? '0 : regfile[src_idx[gi]];
`endif
    end
  endgenerate

  assign hz        = |src_hz;
  assign dec_rdy_o = (!ex_v_reg | ex_rdy_i) & !hz & !flush_i;
  assign accept    = dec_v_i & dec_rdy_o;

  always_comb begin
    ex_v_next = ex_v_reg;
    ex_next   = ex_reg;
    if (flush_i) begin
      ex_v_next = 1'b0;
    end else if (accept) begin
      ex_v_next             = 1'b1;
      ex_next.Stream        = dec_i.Stream;
      ex_next.Stream_inc    = dec_i.Stream_inc;
      ex_next.rid           = dec_i.rid;
      ex_next.ir            = dec_i.ir;
      ex_next.ip            = dec_i.ip;
      ex_next.pip           = dec_i.pip;
      ex_next.predict_taken = dec_i.predict_taken;
      ex_next.ui            = dec_i.ui;
      ex_next.rfwr          = dec_i.rfwr;
      ex_next.Rt            = dec_i.Rt;
      ex_next.imm           = dec_i.imm;
      ex_next.ia            = opnd[0];
      ex_next.ib            = opnd[1];
      ex_next.ic            = opnd[2];
      ex_next.id            = opnd[3];
      ex_next.iav           = 1'b1;
      ex_next.ibv           = 1'b1;
      ex_next.icv           = 1'b1;
      ex_next.idv           = 1'b1;
      ex_next.itv           = dec_i.rfwr;
    end else if (ex_rdy_i) begin
      ex_v_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_v_reg <= 1'b0;
      ex_reg   <= '0;
    end else begin
      ex_v_reg <= ex_v_next;
      ex_reg   <= ex_next;
    end
  end

  assign ex_v_o = ex_v_reg;
  assign ex_o   = ex_reg;

endmodule

// File: tb/tb_any1_regfetch.sv
// Self-checking bench for any1_regfetch: directed scenarios plus a randomized run
// against an array/scoreboard reference model (honours ANY1_RF_BYPASS_EN).
module tb_any1_regfetch;
  import any1_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i;
  logic        dec_v_i;
  logic        dec_rdy_o;
  sDecode      dec_i;
  logic        wb_v_i;
  logic [5:0]  wb_Rt_i;
  logic [63:0] wb_res_i;
  logic        ex_v_o;
  logic        ex_rdy_i;
  sExecute     ex_o;

  any1_regfetch dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .dec_v_i   (dec_v_i),
    .dec_rdy_o (dec_rdy_o),
    .dec_i     (dec_i),
    .wb_v_i    (wb_v_i),
    .wb_Rt_i   (wb_Rt_i),
    .wb_res_i  (wb_res_i),
    .ex_v_o    (ex_v_o),
    .ex_rdy_i  (ex_rdy_i),
    .ex_o      (ex_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_rf [64];
  logic [63:0] m_pend;
  logic        m_ex_v;
  sExecute     m_ex;
  logic        exp_rdy;
  logic        obs_rdy;

  function automatic logic m_hit(input logic [7:0] r);
`ifdef ANY1_RF_BYPASS_EN
    return wb_v_i && (wb_Rt_i == r[5:0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_stalls(input logic [7:0] r);
    return (r[5:0] != 6'd0) && m_pend[r[5:0]] && !m_hit(r);
  endfunction

  function automatic logic [63:0] m_opnd(input logic [7:0] r);
    if (r[5:0] == 6'd0) return 64'd0;
    if (m_hit(r))       return wb_res_i;
    return m_rf[r[5:0]];
  endfunction

  function automatic logic m_rdy();
    logic hz;
    hz = m_stalls(dec_i.Ra) || m_stalls(dec_i.Rb) || m_stalls(dec_i.Rc) || m_stalls(dec_i.Rd);
    return (!m_ex_v || ex_rdy_i) && !hz && !flush_i;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic m_edge();
    logic    acc;
    sExecute e;
    acc = dec_v_i && m_rdy();
    e = m_ex;
    if (acc) begin
      e = '0;
      e.Stream = dec_i.Stream;   e.Stream_inc = dec_i.Stream_inc; e.rid = dec_i.rid;
      e.ir = dec_i.ir;           e.ip = dec_i.ip;                 e.pip = dec_i.pip;
      e.predict_taken = dec_i.predict_taken; e.ui = dec_i.ui;     e.rfwr = dec_i.rfwr;
      e.Rt = dec_i.Rt;           e.imm = dec_i.imm;
      e.ia = m_opnd(dec_i.Ra);   e.ib = m_opnd(dec_i.Rb);
      e.ic = m_opnd(dec_i.Rc);   e.id = m_opnd(dec_i.Rd);
      e.iav = 1'b1; e.ibv = 1'b1; e.icv = 1'b1; e.idv = 1'b1;
      e.itv = dec_i.rfwr;
    end
    if (wb_v_i && wb_Rt_i != 6'd0) m_rf[wb_Rt_i] = wb_res_i;
    if (flush_i) begin
      m_pend = '0;
      m_ex_v = 1'b0;
    end else begin
      if (wb_v_i) m_pend[wb_Rt_i] = 1'b0;
      if (acc) begin
        m_ex   = e;
        m_ex_v = 1'b1;
        if (dec_i.rfwr && dec_i.Rt[5:0] != 6'd0) m_pend[dec_i.Rt[5:0]] = 1'b1;
      end else if (ex_rdy_i) begin
        m_ex_v = 1'b0;
      end
    end
  endtask

  // Inputs are already driven; sample ready mid-cycle, clock once, return just after the edge.
  task automatic cycle();
    #1;
    exp_rdy = m_rdy();
    obs_rdy = dec_rdy_o;
    m_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    dec_v_i = 1'b0; dec_i = '0; wb_v_i = 1'b0; wb_Rt_i = 6'd0; wb_res_i = 64'd0;
    flush_i = 1'b0; ex_rdy_i = 1'b1;
  endtask

  function automatic sDecode mk_dec(input logic [7:0] ra, input logic [7:0] rb,
                                    input logic [7:0] rt, input logic rfwr, input logic [31:0] ir);
    sDecode d;
    d = '0;
    d.Stream = 2'd1; d.rid = ir[5:0]; d.ir = ir; d.ip = ir + 32'd4; d.pip = ir + 32'd8;
    d.predict_taken = ir[0]; d.ui = ir[1]; d.rfwr = rfwr;
    d.Ra = ra; d.Rb = rb; d.Rc = 8'd0; d.Rd = 8'd0; d.Rt = rt;
    d.imm = {ir, ~ir};
    return d;
  endfunction

  function automatic sDecode rand_dec();
    sDecode d;
    d.Stream = 2'($urandom); d.Stream_inc = 1'($urandom); d.rid = 6'($urandom);
    d.ir = $urandom; d.ip = $urandom; d.pip = $urandom;
    d.predict_taken = 1'($urandom); d.ui = 1'($urandom); d.rfwr = 1'($urandom);
    d.Ra = {2'($urandom), 6'($urandom_range(0, 7))};
    d.Rb = {2'($urandom), 6'($urandom_range(0, 7))};
    d.Rc = {2'($urandom), 6'($urandom_range(0, 7))};
    d.Rd = {2'($urandom), 6'($urandom_range(0, 7))};
    d.Rt = {2'($urandom), 6'($urandom_range(0, 7))};
    d.imm = {$urandom, $urandom};
    return d;
  endfunction

  task automatic test_reset();
    idle();
    #1 rst_i = 1'b1;
    m_pend = '0; m_ex_v = 1'b0; m_ex = '0;
    for (int r = 0; r < 64; r++) m_rf[r] = 64'd0;
    repeat (2) @(posedge clk_i);
    #2;
    checks++; if (ex_v_o !== 1'b0) begin errors++; $display("FAIL reset_ex_v got %b want 0", ex_v_o); end
    checks++; if (ex_o !== '0) begin errors++; $display("FAIL reset_ex_o got %h want 0", ex_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    checks++; if (dec_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", dec_rdy_o); end
    // Give every register a known value so random reads are predictable.
    for (int r = 1; r < 64; r++) begin
      wb_v_i = 1'b1; wb_Rt_i = 6'(r); wb_res_i = {$urandom, $urandom};
      cycle();
    end
    idle();
  endtask

  task automatic test_add();
    wb_v_i = 1'b1; wb_Rt_i = 6'd1; wb_res_i = 64'd5; cycle();
    wb_Rt_i = 6'd2; wb_res_i = 64'd7; cycle();
    idle();
    dec_v_i = 1'b1; dec_i = mk_dec(8'd1, 8'd2, 8'd0, 1'b0, 32'h0000_1001);
    cycle();
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL add_rdy got %b want 1", obs_rdy); end
    checks++; if (ex_v_o !== 1'b1) begin errors++; $display("FAIL add_ex_v got %b want 1", ex_v_o); end
    checks++; if (ex_o.ia !== 64'd5 || ex_o.ib !== 64'd7 || ex_o.iav !== 1'b1)
      begin errors++; $display("FAIL add_operands got ia=%0d ib=%0d iav=%b want 5 7 1", ex_o.ia, ex_o.ib, ex_o.iav); end
    checks++; if (ex_o !== m_ex) begin errors++; $display("FAIL add_record got %h want %h", ex_o, m_ex); end
    idle(); cycle();
    checks++; if (ex_v_o !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", ex_v_o); end
  endtask

  task automatic test_raw();
    idle();
    dec_v_i = 1'b1; dec_i = mk_dec(8'd0, 8'd0, 8'd3, 1'b1, 32'h0000_2001);
    cycle();
    dec_i = mk_dec(8'h83, 8'd0, 8'd0, 1'b0, 32'h0000_2002);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall%0d got %b want 0", i, obs_rdy); end
    end
    wb_v_i = 1'b1; wb_Rt_i = 6'd3; wb_res_i = 64'h1234;
    cycle();
`ifdef ANY1_RF_BYPASS_EN
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL raw_bypass_rdy got %b want 1", obs_rdy); end
`else
    checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle_rdy got %b want 0", obs_rdy); end
    wb_v_i = 1'b0;
    cycle();
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL raw_late_rdy got %b want 1", obs_rdy); end
`endif
    checks++; if (ex_v_o !== 1'b1 || ex_o.ia !== 64'h1234)
      begin errors++; $display("FAIL raw_operand got v=%b ia=%h want 1 1234", ex_v_o, ex_o.ia); end
    checks++; if (ex_o !== m_ex) begin errors++; $display("FAIL raw_record got %h want %h", ex_o, m_ex); end
    idle(); cycle();
  endtask

  task automatic test_r0();
    idle();
    wb_v_i = 1'b1; wb_Rt_i = 6'd0; wb_res_i = 64'hFFFF;
    cycle();
    // Second r0 write lands in the same cycle as the read and must not be forwarded.
    dec_v_i = 1'b1; dec_i = mk_dec(8'hC0, 8'd0, 8'd0, 1'b1, 32'h0000_3001);
    cycle();
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL r0_rdy got %b want 1", obs_rdy); end
    checks++; if (ex_o.ia !== 64'd0) begin errors++; $display("FAIL r0_value got %h want 0", ex_o.ia); end
    checks++; if (m_pend !== 64'd0) begin errors++; $display("FAIL r0_model_pend got %h want 0", m_pend); end
    idle(); cycle();
  endtask

  task automatic test_backpressure();
    sExecute a;
    int      delivered;
    idle();
    ex_rdy_i = 1'b0; dec_v_i = 1'b1; dec_i = mk_dec(8'd1, 8'd2, 8'd0, 1'b0, 32'h0000_4001);
    cycle();
    a = ex_o;
    dec_i = mk_dec(8'd2, 8'd1, 8'd0, 1'b0, 32'h0000_4002);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy%0d got %b want 0", i, obs_rdy); end
      checks++; if (ex_v_o !== 1'b1 || ex_o.ir !== 32'h0000_4001 || ex_o !== m_ex)
        begin errors++; $display("FAIL bp_hold%0d got v=%b ir=%h want 1 4001", i, ex_v_o, ex_o.ir); end
    end
    delivered = 0;
    ex_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (ex_v_o && ex_rdy_i && ex_o.ir == a.ir) delivered++;
      cycle();
      dec_v_i = 1'b0;
    end
    checks++; if (delivered != 1) begin errors++; $display("FAIL bp_delivered got %0d want 1", delivered); end
    checks++; if (ex_v_o !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", ex_v_o); end
  endtask

  task automatic test_flush();
    idle();
    ex_rdy_i = 1'b0; dec_v_i = 1'b1; dec_i = mk_dec(8'd0, 8'd0, 8'd5, 1'b1, 32'h0000_5001);
    cycle();
    flush_i = 1'b1; wb_v_i = 1'b1; wb_Rt_i = 6'd6; wb_res_i = 64'hCAFE_0006;
    dec_i = mk_dec(8'd1, 8'd0, 8'd7, 1'b1, 32'h0000_5002);
    cycle();
    checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL flush_rdy got %b want 0", obs_rdy); end
    checks++; if (ex_v_o !== 1'b0) begin errors++; $display("FAIL flush_ex_v got %b want 0", ex_v_o); end
    idle();
    dec_v_i = 1'b1; dec_i = mk_dec(8'd5, 8'd6, 8'd0, 1'b0, 32'h0000_5003);
    cycle();
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL flush_unstall got %b want 1", obs_rdy); end
    checks++; if (ex_o.ib !== 64'hCAFE_0006) begin errors++; $display("FAIL flush_wb got %h want cafe0006", ex_o.ib); end
    checks++; if (ex_o !== m_ex) begin errors++; $display("FAIL flush_record got %h want %h", ex_o, m_ex); end
    idle(); cycle();
  endtask

  task automatic test_set_wins();
    idle();
    dec_v_i = 1'b1; dec_i = mk_dec(8'd0, 8'd0, 8'd4, 1'b1, 32'h0000_6001);
    wb_v_i = 1'b1; wb_Rt_i = 6'd4; wb_res_i = 64'h44;
    cycle();
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL setwins_accept got %b want 1", obs_rdy); end
    wb_v_i = 1'b0;
    dec_i = mk_dec(8'd4, 8'd0, 8'd0, 1'b0, 32'h0000_6002);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL setwins_stall%0d got %b want 0", i, obs_rdy); end
    end
    wb_v_i = 1'b1; wb_Rt_i = 6'd4; wb_res_i = 64'h4444;
    cycle();
    wb_v_i = 1'b0;
    cycle();
    checks++; if (ex_o.ia !== 64'h4444 || ex_o !== m_ex)
      begin errors++; $display("FAIL setwins_read got ia=%h want 4444", ex_o.ia); end
    idle(); cycle();
  endtask

  task automatic test_random();
    int bad;
    idle();
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      dec_v_i  = 1'($urandom);
      dec_i    = rand_dec();
      ex_rdy_i = ($urandom_range(0, 3) != 0);
      wb_v_i   = ($urandom_range(0, 9) < 4);
      wb_Rt_i  = 6'($urandom_range(0, 7));
      wb_res_i = {$urandom, $urandom};
      flush_i  = ($urandom_range(0, 49) == 0);
      cycle();
      checks++;
      if (obs_rdy !== exp_rdy || ex_v_o !== m_ex_v || ex_o !== m_ex) begin
        errors++;
        if (bad < 5)
          $display("FAIL rand%0d got rdy=%b v=%b ia=%h ir=%h want rdy=%b v=%b ia=%h ir=%h",
                   n, obs_rdy, ex_v_o, ex_o.ia, ex_o.ir, exp_rdy, m_ex_v, m_ex.ia, m_ex.ir);
        bad++;
      end
    end
    idle(); cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_raw();
    test_r0();
    test_backpressure();
    test_flush();
    test_set_wins();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
